// File: rtl/morfoloji_kenar_akis_if.sv
// Valid/ready pixel stream used on both sides of the morphology pipeline.
interface morfoloji_kenar_akis_if #(
  parameter int unsigned VERI_W = 8
);
  logic [VERI_W-1:0] veri;
  logic              gecerli;
  logic              hazir;

  modport master (output veri, output gecerli, input hazir);
  modport slave  (input veri, input gecerli, output hazir);
endinterface

// File: rtl/morfoloji_kenar_akis.sv
// Streaming threshold + 3x3 erosion/dilation with boundary extraction.
// Two rows of binarised history are kept in a shift register; no frame memory.
module morfoloji_kenar_akis #(
  parameter int unsigned GENISLIK  = 320,
  parameter int unsigned YUKSEKLIK = 240,
  parameter int unsigned VERI_W    = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  morfoloji_kenar_akis_if.slave  giris,
  morfoloji_kenar_akis_if.master cikis,
  input  logic [VERI_W-1:0]      esik_i,
  input  logic [1:0]             mod_i,
  output logic                   cerceve_bitti_o,
  output logic [1:0]             durum_o
);

  typedef enum logic [1:0] {StAkis = 2'd0, StBosalt = 2'd1, StBitti = 2'd2} durum_e;

  localparam int unsigned Toplam = GENISLIK * YUKSEKLIK;
  localparam int unsigned KSon   = Toplam + GENISLIK + 1;
  localparam int unsigned KW     = $clog2(KSon + 1);
  localparam int unsigned CW     = $clog2(GENISLIK);
  localparam int unsigned SrLen  = 2 * GENISLIK + 2;

  localparam logic [KW-1:0] KSonK    = KW'(KSon);
  localparam logic [KW-1:0] KSonGir  = KW'(Toplam - 1);
  localparam logic [KW-1:0] KIlkCikt = KW'(GENISLIK + 1);
  localparam logic [CW-1:0] CSon     = CW'(GENISLIK - 1);

  durum_e            durum_q, durum_d;
  logic [KW-1:0]     k_q, k_d;
  logic [CW-1:0]     c_q, c_d;
  logic              ilk_q, ilk_d;
  logic [SrLen-1:0]  sr_q, sr_d;
  logic [VERI_W-1:0] esik_q, esik_d;
  logic [1:0]        mod_q, mod_d;
  logic [VERI_W-1:0] veri_q, veri_d;
  logic              gecerli_q, gecerli_d;

  logic              ilerle, kabul, tuket, yukle, yeni_bit, sonuc;
  logic              eroz, dil, ctr;
  logic [VERI_W-1:0] esik_etkin;
  logic [2:0]        ust, orta, alt, kolon_maske;
  logic [8:0]        pencere;

  assign ilerle          = !gecerli_q || cikis.hazir;
  assign giris.hazir     = (durum_q == StAkis) && ilerle;
  assign kabul           = giris.hazir && giris.gecerli;
  // Pixel 0 must already use the threshold being latched with it.
  assign esik_etkin      = (k_q == '0) ? esik_i : esik_q;
  assign yeni_bit        = kabul ? (giris.veri >= esik_etkin) : 1'b0;
  assign tuket           = kabul || ((durum_q == StBosalt) && ilerle && (k_q != KSonK));
  assign yukle           = tuket && (k_q >= KIlkCikt);

  // Bit order in each row: [2] left, [1] centre, [0] right.
  assign ust         = ilk_q ? 3'b000 : {sr_q[2*GENISLIK+1], sr_q[2*GENISLIK], sr_q[2*GENISLIK-1]};
  assign orta        = {sr_q[GENISLIK+1], sr_q[GENISLIK], sr_q[GENISLIK-1]};
  assign alt         = {sr_q[1], sr_q[0], yeni_bit};
  assign kolon_maske = {c_q != '0, 1'b1, c_q != CSon};
  assign pencere     = {ust & kolon_maske, orta & kolon_maske, alt & kolon_maske};
  assign eroz        = &pencere;
  assign dil         = |pencere;
  assign ctr         = orta[1];

  always_comb begin
    sonuc = 1'b0;
    unique case (mod_q)
      2'd0: sonuc = ctr & ~eroz;
      2'd1: sonuc = dil & ~ctr;
      2'd2: sonuc = eroz;
      2'd3: sonuc = dil;
      default: sonuc = 1'b0;
    endcase
  end

  always_comb begin
    durum_d   = durum_q;
    k_d       = k_q;
    c_d       = c_q;
    ilk_d     = ilk_q;
    sr_d      = sr_q;
    esik_d    = esik_q;
    mod_d     = mod_q;
    veri_d    = veri_q;
    gecerli_d = gecerli_q;

    if (cikis.hazir) gecerli_d = 1'b0;
    if (kabul && (k_q == '0)) begin
      esik_d = esik_i;
      mod_d  = mod_i;
    end
    if (tuket) begin
      k_d  = k_q + KW'(1);
      sr_d = {sr_q[SrLen-2:0], yeni_bit};
    end
    if (yukle) begin
      gecerli_d = 1'b1;
      veri_d    = {VERI_W{sonuc}};
      if (c_q == CSon) begin
        c_d   = '0;
        ilk_d = 1'b0;
      end else begin
        c_d = c_q + CW'(1);
      end
    end

    unique case (durum_q)
      StAkis: begin
        if (kabul && (k_q == KSonGir)) durum_d = StBosalt;
      end
      StBosalt: begin
        // With all flush zeros consumed, the held output is the frame's last one.
        if ((k_q == KSonK) && gecerli_q && cikis.hazir) durum_d = StBitti;
      end
      StBitti: begin
        k_d     = '0;
        c_d     = '0;
        ilk_d   = 1'b1;
        durum_d = StAkis;
      end
      default: durum_d = StAkis;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      durum_q   <= StAkis;
      k_q       <= '0;
      c_q       <= '0;
      ilk_q     <= 1'b1;
      sr_q      <= '0;
      esik_q    <= '0;
      mod_q     <= '0;
      veri_q    <= '0;
      gecerli_q <= 1'b0;
    end else begin
      durum_q   <= durum_d;
      k_q       <= k_d;
      c_q       <= c_d;
      ilk_q     <= ilk_d;
      sr_q      <= sr_d;
      esik_q    <= esik_d;
      mod_q     <= mod_d;
      veri_q    <= veri_d;
      gecerli_q <= gecerli_d;
    end
  end

  assign cikis.veri      = veri_q;
  assign cikis.gecerli   = gecerli_q;
  assign cerceve_bitti_o = (durum_q == StBitti);
  assign durum_o         = durum_q;

endmodule

// File: tb/tb_morfoloji_kenar_akis.sv
// Bench for morfoloji_kenar_akis on a 5x4 frame: 2-D padded-window model,
// scoreboard compare on every accepted output, literal pins on the model.
module tb_morfoloji_kenar_akis;
  localparam int G = 5;
  localparam int Y = 4;
  localparam int N = G * Y;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] esik = 8'd0;
  logic [1:0] md = 2'd0;
  logic       bitti;
  logic [1:0] durum;

  morfoloji_kenar_akis_if #(.VERI_W(8)) giris_if ();
  morfoloji_kenar_akis_if #(.VERI_W(8)) cikis_if ();

  morfoloji_kenar_akis #(.GENISLIK(G), .YUKSEKLIK(Y), .VERI_W(8)) dut (
    .clk_i           (clk),
    .rst_i           (rst_n),
    .giris           (giris_if),
    .cikis           (cikis_if),
    .esik_i          (esik),
    .mod_i           (md),
    .cerceve_bitti_o (bitti),
    .durum_o         (durum)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int hz_mod = 0;  // 0: always ready, 1: random, 2: never ready
  logic [7:0]  frame_px [N];
  logic [7:0]  exp_q [$];
  logic [N-1:0] exp_mask;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h t=%0t", nm, got, req, $time);
    end
  endtask

  // Expected frame from the padded 3x3 neighbourhood definition.
  task automatic model(input logic [7:0] es, input logic [1:0] m);
    bit b [Y][G];
    bit er, dl, v, o;
    int rr, cc;
    exp_mask = '0;
    for (int r = 0; r < Y; r++)
      for (int c = 0; c < G; c++) b[r][c] = (frame_px[r*G+c] >= es);
    for (int r = 0; r < Y; r++) begin
      for (int c = 0; c < G; c++) begin
        er = 1'b1;
        dl = 1'b0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            v = (rr >= 0 && rr < Y && cc >= 0 && cc < G) ? b[rr][cc] : 1'b0;
            er = er & v;
            dl = dl | v;
          end
        end
        case (m)
          2'd0: o = b[r][c] & ~er;
          2'd1: o = dl & ~b[r][c];
          2'd2: o = er;
          default: o = dl;
        endcase
        exp_q.push_back(o ? 8'hFF : 8'h00);
        exp_mask[r*G+c] = o;
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (hz_mod)
      0: cikis_if.hazir = 1'b1;
      1: cikis_if.hazir = 1'($urandom_range(0, 1));
      default: cikis_if.hazir = 1'b0;
    endcase
  end

  logic       prev_gec = 1'b0, prev_hz = 1'b0, prev_bitti = 1'b0;
  logic [7:0] prev_veri = 8'h00;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_gec && !prev_hz) begin
        chk("hold_valid", 32'(cikis_if.gecerli), 32'd1);
        chk("hold_data", 32'(cikis_if.veri), 32'(prev_veri));
      end
      if (cikis_if.gecerli && cikis_if.hazir) begin
        if (exp_q.size() == 0) chk("extra_output", 32'(cikis_if.veri), 32'hDEAD);
        else chk("pixel", 32'(cikis_if.veri), 32'(exp_q.pop_front()));
      end
      if (bitti) begin
        pulses++;
        if (prev_bitti) chk("pulse_width", 32'd2, 32'd1);
      end
      prev_gec   = cikis_if.gecerli;
      prev_hz    = cikis_if.hazir;
      prev_veri  = cikis_if.veri;
      prev_bitti = bitti;
    end else begin
      prev_gec   = 1'b0;
      prev_bitti = 1'b0;
    end
  end

  task automatic drive_px(input logic [7:0] v, input bit gaps);
    bit acc;
    int n;
    if (gaps) begin
      int g = int'($urandom_range(0, 2));
      for (int i = 0; i < g; i++) begin
        giris_if.gecerli = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    giris_if.gecerli = 1'b1;
    giris_if.veri    = v;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = giris_if.hazir;
      @(posedge clk);
      #1;
      n++;
    end
    giris_if.gecerli = 1'b0;
    if (!acc) chk("input_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_frame(input logic [7:0] es, input logic [1:0] m, input int chg_idx,
                           input logic [1:0] chg_m, input bit gaps);
    int p0;
    bit seen;
    p0 = pulses;
    model(es, m);
    esik = es;
    md   = m;
    for (int i = 0; i < N; i++) begin
      if (i == chg_idx) md = chg_m;
      drive_px(frame_px[i], gaps);
    end
    @(negedge clk);
    chk("durum_flush", 32'(durum), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (bitti) seen = 1'b1;
    end
    chk("pulse_seen", 32'(seen), 32'd1);
    chk("durum_bitti", 32'(durum), 32'd2);
    @(negedge clk);
    chk("durum_back", 32'(durum), 32'd0);
    chk("pulse_count", 32'(pulses - p0), 32'd1);
    chk("all_outputs", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < N; i++) frame_px[i] = v;
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < N; i++) frame_px[i] = 8'((i * 37 + 11) % 256);
  endtask

  initial begin
    giris_if.gecerli = 1'b0;
    giris_if.veri    = 8'h00;
    cikis_if.hazir   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(cikis_if.gecerli), 32'd0);
    chk("rst_data", 32'(cikis_if.veri), 32'd0);
    chk("rst_durum", 32'(durum), 32'd0);
    chk("rst_pulse", 32'(bitti), 32'd0);
    @(posedge clk);
    #1;

    fill(8'd200);
    run_frame(8'd140, 2'd0, -1, 2'd0, 1'b0);
    chk("pin_ring", 32'(exp_mask), 32'hFC63F);

    fill(8'd0);
    frame_px[2*G+2] = 8'd255;
    run_frame(8'd140, 2'd3, -1, 2'd0, 1'b0);
    chk("pin_dilate", 32'(exp_mask), 32'h739C0);
    run_frame(8'd140, 2'd2, -1, 2'd0, 1'b0);
    chk("pin_erode", 32'(exp_mask), 32'h0);

    fill(8'd100);
    run_frame(8'd100, 2'd2, -1, 2'd0, 1'b0);
    chk("pin_eq_thr", 32'(exp_mask), 32'h39C0);
    run_frame(8'd101, 2'd2, -1, 2'd0, 1'b0);
    chk("pin_below_thr", 32'(exp_mask), 32'h0);

    fill_pattern();
    run_frame(8'd128, 2'd1, -1, 2'd0, 1'b0);
    hz_mod = 1;
    run_frame(8'd128, 2'd1, -1, 2'd0, 1'b1);
    run_frame(8'd128, 2'd0, -1, 2'd0, 1'b1);
    hz_mod = 0;

    run_frame(8'd128, 2'd0, 7, 2'd3, 1'b0);
    run_frame(8'd128, 2'd3, -1, 2'd0, 1'b0);

    // Abort a frame after 7 pixels with the output side stalled.
    begin
      int p0;
      p0 = pulses;
      hz_mod = 2;
      @(posedge clk);
      #1;
      esik = 8'd128;
      md   = 2'd0;
      for (int i = 0; i < 7; i++) drive_px(frame_px[i], 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      hz_mod = 0;
      @(negedge clk);
      chk("abort_valid", 32'(cikis_if.gecerli), 32'd0);
      chk("abort_data", 32'(cikis_if.veri), 32'd0);
      chk("abort_durum", 32'(durum), 32'd0);
      chk("abort_nopulse", 32'(pulses - p0), 32'd0);
      @(posedge clk);
      #1;
    end
    fill_pattern();
    frame_px[3] = 8'd250;
    run_frame(8'd128, 2'd0, -1, 2'd0, 1'b0);

    repeat (5) @(posedge clk);
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1);
  end
endmodule
